// File: rtl/line_matrix_v2.sv
// GPIO-programmed routing matrix: strobed writes fill a shadow map, a commit strobe
// swaps it into the active map that drives registered pass/invert/stretch outputs.
module line_matrix_v2 #(
  parameter int N_IN        = 8,
  parameter int N_OUT       = 9,
  parameter int ISEL_W      = 4,
  parameter int OSEL_W      = 4,
  parameter int STRETCH_LEN = 16
) (
  input  logic              sys_clk,
  input  logic              rstn,
  input  logic              clk_pin,
  input  logic              commit_pin,
  input  logic [ISEL_W-1:0] input_select,
  input  logic [OSEL_W-1:0] output_select,
  input  logic [1:0]        mode_select,
  input  logic [N_IN-1:0]   input_lines,
  output logic [N_OUT-1:0]  output_lines,
  output logic              sel_err,
  output logic [7:0]        wr_count
);

  localparam int ENT_W = ISEL_W + 3;
  localparam int IPAD  = 2 ** ISEL_W;
  localparam logic [7:0]      STRETCH_INIT = 8'(STRETCH_LEN);
  localparam logic [OSEL_W:0] OSEL_LIM     = (OSEL_W + 1)'(N_OUT);
  localparam logic [ISEL_W:0] ISEL_LIM     = (ISEL_W + 1)'(N_IN);
  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INV  = 2'b01;
  localparam logic [1:0] MODE_STR  = 2'b10;

  // Strobe vectors: bit 0 is clk_pin, bit 1 is commit_pin.
  logic [1:0]        strb_s1_q, strb_s1_d, strb_s2_q, strb_s2_d, strb_prev_q, strb_prev_d;
  logic [N_IN-1:0]   in_s1_q, in_s1_d, in_s2_q, in_s2_d, in_prev_q, in_prev_d;
  logic [1:0]        warm_q, warm_d;
  logic [ENT_W-1:0]  shadow_q [N_OUT];
  logic [ENT_W-1:0]  shadow_d [N_OUT];
  logic [ENT_W-1:0]  active_q [N_OUT];
  logic [ENT_W-1:0]  active_d [N_OUT];
  logic [7:0]        cnt_q [N_OUT];
  logic [7:0]        cnt_d [N_OUT];
  logic [N_OUT-1:0]  out_q, out_d;
  logic              sel_err_q, sel_err_d;
  logic [7:0]        wr_count_q, wr_count_d;

  logic              armed, clk_rise, commit_rise, osel_ok, isel_ok;
  logic [1:0]        strb_rise;
  logic [IPAD-1:0]   in_pad, rise_pad;

  // Edge detection stays off until the history flop holds a post-reset sample,
  // so a line already high at reset release never looks like a fresh edge.
  always_comb begin
    strb_s1_d   = {commit_pin, clk_pin};
    strb_s2_d   = strb_s1_q;
    strb_prev_d = strb_s2_q;
    in_s1_d     = input_lines;
    in_s2_d     = in_s1_q;
    in_prev_d   = in_s2_q;
    armed       = (warm_q == 2'd3);
    warm_d      = armed ? 2'd3 : warm_q + 2'd1;
    strb_rise   = strb_s2_q & ~strb_prev_q & {2{armed}};
    clk_rise    = strb_rise[0];
    commit_rise = strb_rise[1];
    in_pad      = '0;
    rise_pad    = '0;
    in_pad[N_IN-1:0]   = in_s2_q;
    rise_pad[N_IN-1:0] = in_s2_q & ~in_prev_q & {N_IN{armed}};
  end

  // Write lands in the shadow first; commit copies shadow_d so a same-cycle
  // write is part of the committed map.
  always_comb begin
    osel_ok    = ({1'b0, output_select} < OSEL_LIM);
    isel_ok    = ({1'b0, input_select} < ISEL_LIM);
    sel_err_d  = sel_err_q | (clk_rise & (~osel_ok | ~isel_ok));
    wr_count_d = (clk_rise && osel_ok) ? wr_count_q + 8'd1 : wr_count_q;
    for (int o = 0; o < N_OUT; o++) begin
      shadow_d[o] = shadow_q[o];
      if (clk_rise && osel_ok && (output_select == o[OSEL_W-1:0]))
        shadow_d[o] = {isel_ok, mode_select, input_select};
      active_d[o] = commit_rise ? shadow_d[o] : active_q[o];
    end
  end

  logic [ENT_W-1:0]  ent;
  logic [ISEL_W-1:0] ent_sel;
  logic [1:0]        ent_mode;
  logic              ent_en;

  always_comb begin
    out_d    = '0;
    ent      = '0;
    ent_sel  = '0;
    ent_mode = '0;
    ent_en   = 1'b0;
    for (int o = 0; o < N_OUT; o++) begin
      ent      = active_q[o];
      ent_en   = ent[ENT_W-1];
      ent_mode = ent[ENT_W-2 -: 2];
      ent_sel  = ent[ISEL_W-1:0];
      cnt_d[o] = 8'd0;
      if (ent_en && (ent_mode == MODE_STR)) begin
        if (rise_pad[ent_sel])     cnt_d[o] = STRETCH_INIT;
        else if (cnt_q[o] != 8'd0) cnt_d[o] = cnt_q[o] - 8'd1;
      end
      // A remapped output must not inherit the old source's pulse.
      if (commit_rise && (active_d[o] != active_q[o])) cnt_d[o] = 8'd0;
      if (ent_en) begin
        case (ent_mode)
          MODE_PASS: out_d[o] = in_pad[ent_sel];
          MODE_INV:  out_d[o] = ~in_pad[ent_sel];
          MODE_STR:  out_d[o] = (cnt_q[o] != 8'd0);
          default:   out_d[o] = 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rstn) begin
      strb_s1_q   <= '0;
      strb_s2_q   <= '0;
      strb_prev_q <= '0;
      in_s1_q     <= '0;
      in_s2_q     <= '0;
      in_prev_q   <= '0;
      warm_q      <= '0;
      out_q       <= '0;
      sel_err_q   <= 1'b0;
      wr_count_q  <= '0;
      for (int o = 0; o < N_OUT; o++) begin
        shadow_q[o] <= '0;
        active_q[o] <= '0;
        cnt_q[o]    <= '0;
      end
    end else begin
      strb_s1_q   <= strb_s1_d;
      strb_s2_q   <= strb_s2_d;
      strb_prev_q <= strb_prev_d;
      in_s1_q     <= in_s1_d;
      in_s2_q     <= in_s2_d;
      in_prev_q   <= in_prev_d;
      warm_q      <= warm_d;
      out_q       <= out_d;
      sel_err_q   <= sel_err_d;
      wr_count_q  <= wr_count_d;
      for (int o = 0; o < N_OUT; o++) begin
        shadow_q[o] <= shadow_d[o];
        active_q[o] <= active_d[o];
        cnt_q[o]    <= cnt_d[o];
      end
    end
  end

  assign output_lines = out_q;
  assign sel_err      = sel_err_q;
  assign wr_count     = wr_count_q;

endmodule

// File: tb/tb_line_matrix_v2.sv
// Bench for line_matrix_v2: directed scenarios then random traffic, every cycle's
// outputs compared against a window-based reference model through a scoreboard queue.
module tb_line_matrix_v2;

  localparam int N_IN  = 8;
  localparam int N_OUT = 9;
  localparam int SLEN  = 16;
  localparam int MAXC  = 8000;
  localparam int W     = N_OUT + 9;

  logic             sys_clk = 1'b0;
  logic             rstn = 1'b0;
  logic             clk_pin = 1'b0;
  logic             commit_pin = 1'b0;
  logic [3:0]       input_select = '0;
  logic [3:0]       output_select = '0;
  logic [1:0]       mode_select = '0;
  logic [N_IN-1:0]  input_lines = '0;
  logic [N_OUT-1:0] output_lines;
  logic             sel_err;
  logic [7:0]       wr_count;

  line_matrix_v2 #(.N_IN(N_IN), .N_OUT(N_OUT), .ISEL_W(4), .OSEL_W(4), .STRETCH_LEN(SLEN)) dut (
    .sys_clk(sys_clk), .rstn(rstn), .clk_pin(clk_pin), .commit_pin(commit_pin),
    .input_select(input_select), .output_select(output_select), .mode_select(mode_select),
    .input_lines(input_lines), .output_lines(output_lines), .sel_err(sel_err),
    .wr_count(wr_count)
  );

  // ---------------- clock ----------------
  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model ----------------
  logic [N_IN-1:0] d_in [MAXC];
  bit              d_clk [MAXC];
  bit              d_com [MAXC];
  int sh_en [N_OUT], sh_mode [N_OUT], sh_sel [N_OUT];
  int ac_en [N_OUT], ac_mode [N_OUT], ac_sel [N_OUT], act_time [N_OUT];
  int m_err = 0, m_wc = 0, rel = 0, cyc = 0;
  logic [W-1:0] exp_q [$];
  int n_checks = 0, n_fail = 0;
  bit rnd_in = 1'b0;

  // Input line value sampled at edge k; nothing before the last reset edge is visible.
  function automatic bit hin(int k, int s);
    if (k <= rel || k < 0 || k >= MAXC) return 1'b0;
    return d_in[k][s];
  endfunction

  // Pass/invert see the line two edges back; stretch is high when a rising edge
  // of the source falls inside the last SLEN-cycle window and after the entry went live.
  function automatic bit model_out(int o, int t);
    if (ac_en[o] == 0 || ac_mode[o] == 3) return 1'b0;
    if (ac_mode[o] == 0) return hin(t - 2, ac_sel[o]);
    if (ac_mode[o] == 1) return !hin(t - 2, ac_sel[o]);
    for (int r = t - 2 - SLEN; r <= t - 3; r++)
      if ((r + 2 >= rel + 4) && (r + 2 > act_time[o]) && hin(r, ac_sel[o]) && !hin(r - 1, ac_sel[o]))
        return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge sys_clk) begin : model
    logic [N_OUT-1:0] eo;
    int  t, os;
    bit  wr, cm;
    cyc = cyc + 1;
    t   = cyc;
    if (t < MAXC) begin
      d_in[t]  = input_lines;
      d_clk[t] = clk_pin;
      d_com[t] = commit_pin;
    end
    eo = '0;
    if (!rstn) begin
      for (int o = 0; o < N_OUT; o++) begin
        sh_en[o] = 0; sh_mode[o] = 0; sh_sel[o] = 0;
        ac_en[o] = 0; ac_mode[o] = 0; ac_sel[o] = 0; act_time[o] = t;
      end
      m_err = 0; m_wc = 0; rel = t;
    end else begin
      for (int o = 0; o < N_OUT; o++) eo[o] = model_out(o, t);
      wr = (t >= rel + 4) && d_clk[t-2] && !d_clk[t-3];
      cm = (t >= rel + 4) && d_com[t-2] && !d_com[t-3];
      if (wr) begin
        os = int'(output_select);
        if (os >= N_OUT) m_err = 1;
        else begin
          m_wc = (m_wc + 1) % 256;
          sh_en[os]   = (int'(input_select) < N_IN) ? 1 : 0;
          if (sh_en[os] == 0) m_err = 1;
          sh_mode[os] = int'(mode_select);
          sh_sel[os]  = int'(input_select);
        end
      end
      if (cm)
        for (int o = 0; o < N_OUT; o++)
          if (sh_en[o] != ac_en[o] || sh_mode[o] != ac_mode[o] || sh_sel[o] != ac_sel[o]) begin
            ac_en[o] = sh_en[o]; ac_mode[o] = sh_mode[o]; ac_sel[o] = sh_sel[o];
            act_time[o] = t;
          end
    end
    exp_q.push_back({eo, m_err[0], m_wc[7:0]});
  end

  // ---------------- scoreboard monitor ----------------
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge sys_clk) begin : monitor
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("output_lines", 32'(output_lines), 32'(e[W-1:9]));
      chk("sel_err", 32'(sel_err), 32'(e[8]));
      chk("wr_count", 32'(wr_count), 32'(e[7:0]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wiggle();
    int b;
    if ($urandom_range(0, 2) == 0) begin
      b = $urandom_range(0, N_IN - 1);
      input_lines[b] = ~input_lines[b];
    end
  endtask

  task automatic idle(int n);
    repeat (n) begin
      @(negedge sys_clk);
      if (rnd_in) wiggle();
    end
  endtask

  task automatic strobe(int o, int i, int m, bit do_wr, bit do_cm);
    @(negedge sys_clk);
    output_select = 4'(o);
    input_select  = 4'(i);
    mode_select   = 2'(m);
    clk_pin       = do_wr;
    commit_pin    = do_cm;
    idle(4);
    @(negedge sys_clk);
    clk_pin    = 1'b0;
    commit_pin = 1'b0;
    idle(2);
  endtask

  task automatic do_write(int o, int i, int m);
    strobe(o, i, m, 1'b1, 1'b0);
  endtask

  task automatic do_commit();
    strobe(int'(output_select), int'(input_select), int'(mode_select), 1'b0, 1'b1);
  endtask

  task automatic pulse_in(int b);
    @(negedge sys_clk);
    input_lines[b] = 1'b1;
    @(negedge sys_clk);
    input_lines[b] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle(4);
    @(negedge sys_clk);
    rstn = 1'b1;
    idle(4);

    // pass route 5 -> 2
    do_write(2, 5, 0);
    do_commit();
    @(negedge sys_clk); input_lines[5] = 1'b1;
    idle(6);
    @(negedge sys_clk); input_lines[5] = 1'b0;
    idle(6);

    // stretch on 1 -> 0, single pulse then retrigger 10 cycles apart
    do_write(0, 1, 2);
    do_commit();
    pulse_in(1);
    idle(22);
    pulse_in(1);
    idle(8);
    pulse_in(1);
    idle(32);

    // invert route staged without commit, then committed
    do_write(3, 6, 1);
    idle(6);
    do_commit();
    idle(4);

    // out-of-range destination, then out-of-range source
    do_write(12, 0, 0);
    do_write(7, 10, 0);
    idle(4);

    // write and commit in the same cycle
    strobe(4, 2, 1, 1'b1, 1'b1);
    idle(4);

    // reset in the middle of a stretch with clk_pin held high across release
    do_write(5, 3, 2);
    do_commit();
    pulse_in(3);
    idle(5);
    @(negedge sys_clk);
    output_select = 4'd1;
    clk_pin = 1'b1;
    rstn    = 1'b0;
    idle(3);
    @(negedge sys_clk);
    rstn = 1'b1;
    idle(8);
    @(negedge sys_clk);
    clk_pin = 1'b0;
    idle(4);

    // random traffic
    rnd_in = 1'b1;
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(0, 7))
        0, 1:    do_commit();
        2:       strobe($urandom_range(0, 9), $urandom_range(0, 8), $urandom_range(0, 3), 1'b1, 1'b1);
        3:       idle($urandom_range(1, 12));
        default: do_write($urandom_range(0, 10), $urandom_range(0, 9), $urandom_range(0, 3));
      endcase
    end
    rnd_in = 1'b0;
    idle(4);

    @(negedge sys_clk);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_matrix_v2.md
LINE_MATRIX_V2 -- requirements
Module: line_matrix_v2

Interface
REQ-001 Parameter N_IN, default 8, number of input lines.
REQ-002 Parameter N_OUT, default 9, number of output lines.
REQ-003 Parameter ISEL_W, default 4, input-select width; SHALL satisfy 2**ISEL_W >= N_IN.
REQ-004 Parameter OSEL_W, default 4, output-select width; SHALL satisfy 2**OSEL_W >= N_OUT.
REQ-005 Parameter STRETCH_LEN, default 16, stretch-mode hold length in sys_clk cycles, range 1..255.
REQ-006 Port: sys_clk, in, 1, single clock for all logic.
REQ-007 Port: rstn, in, 1, reset, synchronous to sys_clk, active-low.
REQ-008 Port: clk_pin, in, 1, asynchronous write strobe from GPIO; each rising edge writes one shadow entry.
REQ-009 Port: commit_pin, in, 1, asynchronous; each rising edge copies the shadow table to the active table.
REQ-010 Port: input_select, in, ISEL_W, source index for the entry being written.
REQ-011 Port: output_select, in, OSEL_W, destination index of the entry being written.
REQ-012 Port: mode_select, in, 2, mode: 00 pass, 01 invert, 10 stretch, 11 disabled (drive 0).
REQ-013 Port: input_lines, in, N_IN, asynchronous source lines.
REQ-014 Port: output_lines, out, N_OUT, registered routed outputs.
REQ-015 Port: sel_err, out, 1, sticky out-of-range flag.
REQ-016 Port: wr_count, out, 8, number of accepted writes, wraps 255->0.

Function
REQ-017 clk_pin, commit_pin and input_lines SHALL each pass through a 2-flop synchroniser; rising edges are detected from synchronised current vs previous value.
REQ-018 Per output, the shadow and active tables SHALL each hold {en, mode[1:0], sel[ISEL_W-1:0]}.
REQ-019 clk_pin edge with output_select < N_OUT: shadow[output_select] <= {1, mode_select, input_select}; wr_count increments.
REQ-020 clk_pin edge with output_select >= N_OUT: write dropped, wr_count unchanged, sel_err set.
REQ-021 clk_pin edge with input_select >= N_IN: entry written with en=0, sel_err set, wr_count increments.
REQ-022 Select and mode inputs SHALL be sampled in the cycle the synchronised clk_pin edge is detected; software holds them stable across the strobe.
REQ-023 commit_pin edge: the active table SHALL be loaded with the whole shadow table in one cycle; outputs never see a partially updated map.
REQ-024 clk_pin and commit_pin edges detected in the same cycle: the write SHALL be applied first and the commit SHALL include the new entry.
REQ-025 Pass mode: output_lines[o] <= sync_in[sel]; invert mode: <= ~sync_in[sel]; disabled or en=0: <= 0.
REQ-026 Latency, pass/invert: input_lines change to output_lines change SHALL take 3 sys_clk cycles (2 sync + 1 output register).
REQ-027 Stretch mode: each output has an 8-bit down-counter; a rising edge of sync_in[sel] loads STRETCH_LEN; output is 1 while counter != 0.
REQ-028 Stretch retrigger: a rising edge while the counter is nonzero SHALL reload STRETCH_LEN, with no gap in output.
REQ-029 Stretch output SHALL rise 4 cycles after the input edge and stay high exactly STRETCH_LEN cycles after a single edge.
REQ-030 On commit, any output whose active entry changes SHALL clear its stretch counter; unchanged entries keep counting.
REQ-031 sel_err SHALL stay set until reset; no other clear path.

Reset
REQ-032 While rstn=0 at a sys_clk edge: shadow and active entries all 0 (en=0), output_lines=0, stretch counters=0, sel_err=0, wr_count=0, synchroniser and edge-history flops=0.
REQ-033 Reset asserted mid-operation SHALL abandon any pending edge; an input or strobe held high through reset release SHALL NOT produce an edge.

Verification
REQ-034 Write out=2, in=5, mode=00, then commit; toggle input_lines[5] -> output_lines[2] follows 3 cycles later, all other outputs stay 0.
REQ-035 Write out=0, in=1, mode=10, STRETCH_LEN=16, commit; pulse in[1] for 1 cycle -> out[0] high for 16 cycles; second pulse 10 cycles later -> high for 26 cycles total.
REQ-036 Write out=3 mode=01 without commit -> out[3] stays 0; commit -> out[3]=~in[sel] within 3 cycles of the synchronised commit edge.
REQ-037 Write output_select=12 (N_OUT=9) -> sel_err=1, wr_count unchanged; write input_select=10 (N_IN=8) -> entry disabled, sel_err=1, wr_count+1.
REQ-038 Same-cycle clk_pin and commit_pin edges writing out=4 -> active entry 4 holds the new value after that cycle.
REQ-039 Assert rstn low mid-stretch with clk_pin held high -> all outputs 0 the next cycle; release rstn -> no write occurs, wr_count=0.
